// File: rtl/seq_div.sv
// seq_div: multi-cycle signed integer divider (non-restoring, one quotient bit
// per clock). Quotient truncates toward zero and the remainder takes the sign
// of the dividend. Result is packed {remainder, quotient} for HI/LO.
// Build option: DIV_SIGNED_EN -- when defined, operands are two's complement;
// when undefined, operands are unsigned and the sign handling is removed
// (FIX still runs the remainder correction so latency is identical).
module seq_div #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic               div_by_zero,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic [2*WIDTH-1:0] result
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH:0]     rem_q;     // partial remainder, one extra sign bit
   logic [WIDTH-1:0]   quo_q;     // dividend magnitude shifting out, quotient shifting in
   logic [WIDTH-1:0]   dvs_q;     // divisor magnitude
   logic [CNT_W-1:0]   cnt_q;
   logic               dbz_q;
`ifdef DIV_SIGNED_EN
   logic               sign_q;
   logic               sign_r;
`endif

   logic               accept;
   logic [WIDTH-1:0]   mag_dividend;
   logic [WIDTH-1:0]   mag_divisor;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     rem_step;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   q_out;
   logic [WIDTH-1:0]   r_out;

   // A start in the done cycle is ignored: state is already IDLE there,
   // so the done flag itself gates acceptance.
   assign accept = (state == S_IDLE) && start && !done;
   assign busy   = (state != S_IDLE);
   assign result = {remainder, quotient};

   // Operand magnitudes, sign step per iteration, and final correction.
   always_comb begin
`ifdef DIV_SIGNED_EN
      mag_dividend = dividend[WIDTH-1] ? -dividend : dividend;
      mag_divisor  = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
      mag_dividend = dividend;
      mag_divisor  = divisor;
`endif
      // Intermediate shift may wrap for large unsigned divisors, but the
      // add/subtract result always lies in [-d, d) so it is exact mod 2^(W+1).
      rem_sh   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      rem_step = rem_q[WIDTH] ? (rem_sh + {1'b0, dvs_q}) : (rem_sh - {1'b0, dvs_q});
      rem_fix  = rem_q[WIDTH] ? (rem_q[WIDTH-1:0] + dvs_q) : rem_q[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
      q_out    = sign_q ? -quo_q   : quo_q;
      r_out    = sign_r ? -rem_fix : rem_fix;
`else
      q_out    = quo_q;
      r_out    = rem_fix;
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = (divisor == '0) ? S_DONE : S_CALC;
         S_CALC: if (cnt_q == CNT_W'(1)) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Working datapath: operand latch, iteration, sign/remainder correction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         dbz_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
         sign_q <= 1'b0;
         sign_r <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  dvs_q <= mag_divisor;
                  cnt_q <= CNT_W'(WIDTH);
`ifdef DIV_SIGNED_EN
                  sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  sign_r <= dividend[WIDTH-1];
`endif
                  if (divisor == '0) begin
                     quo_q <= '1;
                     rem_q <= {dividend[WIDTH-1], dividend};
                     dbz_q <= 1'b1;
                  end else begin
                     quo_q <= mag_dividend;
                     rem_q <= '0;
                     dbz_q <= 1'b0;
                  end
               end
            end
            S_CALC: begin
               rem_q <= rem_step;
               quo_q <= {quo_q[WIDTH-2:0], ~rem_step[WIDTH]};
               cnt_q <= cnt_q - CNT_W'(1);
            end
            S_FIX: begin
               quo_q <= q_out;
               rem_q <= {1'b0, r_out};
            end
            default: ;
         endcase
      end
   end

   // Result registers: updated only in DONE, held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
      end else begin
         done <= 1'b0;
         if (state == S_DONE) begin
            done        <= 1'b1;
            div_by_zero <= dbz_q;
            quotient    <= quo_q;
            remainder   <= rem_q[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed vectors for seq_div with hand-computed results.
// Expected values follow the DIV_SIGNED_EN build setting.
module tb_seq_div;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic [63:0] result;

   int tests_run = 0;
   int tests_failed = 0;

   seq_div #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .quotient    (quotient),
      .remainder   (remainder),
      .result      (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one division, optionally poke a (to-be-ignored) start at cycle
   // poke_at while busy, then check latency, results and the done pulse.
   // A start is also driven in the done cycle; it must be ignored.
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                          input int elat, input int poke_at);
      int lat;
      bit got;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, ".busy_after_start"}, 64'(busy), 64'(1));
      lat = 0;
      got = 0;
      while (!got && lat < 100) begin
         if (poke_at > 0 && lat == poke_at) begin
            dividend = 32'd9;
            divisor  = 32'd3;
            start    = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         lat++;
         if (done) got = 1;
      end
      check({tag, ".latency"}, got ? 64'(lat) : 64'hDEAD, 64'(elat));
      check({tag, ".quotient"}, 64'(quotient), 64'(eq));
      check({tag, ".remainder"}, 64'(remainder), 64'(er));
      check({tag, ".result"}, result, {er, eq});
      check({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(edbz));
      check({tag, ".busy_in_done"}, 64'(busy), 64'(0));
      dividend = 32'd9;
      divisor  = 32'd3;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, ".done_pulse"}, 64'(done), 64'(0));
      check({tag, ".start_in_done_ignored"}, 64'(busy), 64'(0));
   endtask

   initial begin
      int seen;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.busy", 64'(busy), 64'(0));
      check("rst.done", 64'(done), 64'(0));
      check("rst.dbz", 64'(div_by_zero), 64'(0));
      check("rst.quotient", 64'(quotient), 64'(0));
      check("rst.remainder", 64'(remainder), 64'(0));
      check("rst.result", result, 64'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic, and a busy-time start at cycle 10 that must be ignored.
      run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 10);
      // Accepted in the cycle right after the done cycle's ignored start.
      run_div("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34, 0);

`ifdef DIV_SIGNED_EN
      run_div("dm7_2",  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 0);
      run_div("d7_m2",  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 34, 0);
      run_div("dm7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0, 34, 0);
      run_div("dmin_1", 32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,         1'b0, 34, 0);
      run_div("dmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0, 34, 0);
`else
      run_div("dm7_2",  32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 32'd1,         1'b0, 34, 0);
      run_div("d7_m2",  32'd7,         32'hFFFF_FFFE, 32'd0,         32'd7,         1'b0, 34, 0);
      run_div("dm7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd0,         32'hFFFF_FFF9, 1'b0, 34, 0);
      run_div("dmin_1", 32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,         1'b0, 34, 0);
      run_div("dmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, 34, 0);
`endif
      run_div("d5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0);
      run_div("d9_3b", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34, 0);

      // Reset mid-operation: outputs clear at once, no done afterwards.
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort.busy", 64'(busy), 64'(0));
      check("abort.done", 64'(done), 64'(0));
      check("abort.dbz", 64'(div_by_zero), 64'(0));
      check("abort.quotient", 64'(quotient), 64'(0));
      check("abort.remainder", 64'(remainder), 64'(0));
      check("abort.result", result, 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || busy) seen++;
      end
      check("abort.idle_after", 64'(seen), 64'(0));
      run_div("d20_6", 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 34, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
